// File: rtl/seq_detector_param.sv
// Serial pattern detector: runtime-loadable PAT_W-bit pattern, overlap/non-overlap modes, saturating match count.
// q_out is combinational from the completing d_in (0 cycles); match_cnt updates 1 cycle later; en stalls the stream.
module seq_detector_param #(
  parameter int                 PAT_W           = 3,
  parameter int                 CNT_W           = 8,
  parameter logic [PAT_W-1:0]   DEFAULT_PATTERN = 3'b101,
  parameter logic               DEFAULT_OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             d_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             q_out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int             FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] r_pat;
  logic             r_mode;
  logic [PAT_W-2:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W-1:0] w_window;
  logic             w_match;

  // Oldest stored bit sits in the MSB so the window lines up with the pattern's first-received bit.
  assign w_window = {r_hist, d_in};
  assign w_match  = en & ~cfg_load & (r_fill == FILL_MAX) & (w_window == r_pat);
  assign q_out     = w_match;
  assign match_cnt = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat  <= DEFAULT_PATTERN;
      r_mode <= DEFAULT_OVERLAP;
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_mode <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      if (w_match && !r_mode) begin
        // Non-overlapping: matched bits are consumed and cannot seed the next match.
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[PAT_W-2:0];
        if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default 3-bit, narrow-counter and 4-bit-pattern instances.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       d_in = 1'b0;
  logic       cfg_load = 1'b0;
  logic       cfg_overlap = 1'b1;
  logic       cnt_clr = 1'b0;
  logic [2:0] cfg_pat3 = 3'b101;
  logic [3:0] cfg_pat4 = 4'b1101;

  logic       q0, q1, q2;
  logic [7:0] cnt0;
  logic [3:0] cnt1;
  logic [7:0] cnt2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(3), .CNT_W(8), .DEFAULT_PATTERN(3'b101), .DEFAULT_OVERLAP(1'b1)) u_def (
    .clk(clk), .reset_n(reset_n), .en(en), .d_in(d_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pat3), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .q_out(q0), .match_cnt(cnt0));

  seq_detector_param #(.PAT_W(3), .CNT_W(4), .DEFAULT_PATTERN(3'b101), .DEFAULT_OVERLAP(1'b1)) u_c4 (
    .clk(clk), .reset_n(reset_n), .en(en), .d_in(d_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pat3), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .q_out(q1), .match_cnt(cnt1));

  seq_detector_param #(.PAT_W(4), .CNT_W(8), .DEFAULT_PATTERN(4'b0110), .DEFAULT_OVERLAP(1'b1)) u_p4 (
    .clk(clk), .reset_n(reset_n), .en(en), .d_in(d_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pat4), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .q_out(q2), .match_cnt(cnt2));

  // Previous inputs are clocked in, new ones applied, and control returns at the falling edge for sampling.
  task automatic cyc(input logic e, input logic d, input logic ld, input logic clr);
    @(posedge clk);
    #1;
    en = e; d_in = d; cfg_load = ld; cnt_clr = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0; en = 1'b0; d_in = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0; en = 1'b1; d_in = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({q0, q1, q2} !== 3'b000) $display("FAIL reset_q: got %b want 000", {q0, q1, q2});
    else n_pass++;
    n_total++;
    if (cnt0 !== 8'd0 || cnt1 !== 4'd0 || cnt2 !== 8'd0)
      $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", cnt0, cnt1, cnt2);
    else n_pass++;
    en = 1'b0; d_in = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [4:0] bits = 5'b10101;
    logic [4:0] expq = 5'b00101;
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      cyc(1'b1, bits[i], 1'b0, 1'b0);
      n_total++;
      if (q0 !== expq[i]) $display("FAIL overlap_q bit%0d: got %b want %b", 5 - i, q0, expq[i]);
      else n_pass++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (cnt0 !== 8'd2) $display("FAIL overlap_cnt: got %0d want 2", cnt0);
    else n_pass++;
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits = 7'b1010101;
    logic [6:0] expq = 7'b0010001;
    do_reset();
    cfg_pat3 = 3'b101;
    cfg_overlap = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (q0 !== 1'b0) $display("FAIL nonovl_load_q: got %b want 0", q0);
    else n_pass++;
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, bits[i], 1'b0, 1'b0);
      n_total++;
      if (q0 !== expq[i]) $display("FAIL nonovl_q bit%0d: got %b want %b", 7 - i, q0, expq[i]);
      else n_pass++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (cnt0 !== 8'd2) $display("FAIL nonovl_cnt: got %0d want 2", cnt0);
    else n_pass++;
    cfg_overlap = 1'b1;
  endtask

  task automatic test_en_gating();
    logic [4:0] ens  = 5'b11001;
    logic [4:0] bits = 5'b10001;
    logic [4:0] expq = 5'b00001;
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      cyc(ens[i], bits[i], 1'b0, 1'b0);
      n_total++;
      if (q0 !== expq[i]) $display("FAIL engate_q step%0d: got %b want %b", 5 - i, q0, expq[i]);
      else n_pass++;
    end
    // Window 10 + pending 1 would match, but en=0 must mask it.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (q0 !== 1'b0) $display("FAIL engate_masked: got %b want 0", q0);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic [2:0] bits = 3'b101;
    logic [2:0] expq = 3'b001;
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (q0 !== 1'b0 || cnt0 !== 8'd0) $display("FAIL midrst_in_reset: got q=%b cnt=%0d want q=0 cnt=0", q0, cnt0);
    else n_pass++;
    #2;
    reset_n = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      cyc(1'b1, bits[i], 1'b0, 1'b0);
      n_total++;
      if (q0 !== expq[i]) $display("FAIL midrst_q bit%0d: got %b want %b", 3 - i, q0, expq[i]);
      else n_pass++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (cnt0 !== 8'd1) $display("FAIL midrst_cnt: got %0d want 1", cnt0);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int m = 1; m <= 20; m++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (m > 1) begin
        want = (m - 1 > 15) ? 15 : m - 1;
        n_total++;
        if (cnt1 !== 4'(want)) $display("FAIL sat_cnt m%0d: got %0d want %0d", m - 1, cnt1, want);
        else n_pass++;
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_total++;
      if (q1 !== 1'b1) $display("FAIL sat_q m%0d: got %b want 1", m, q1);
      else n_pass++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (cnt1 !== 4'd15) $display("FAIL sat_final: got %0d want 15", cnt1);
    else n_pass++;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    n_total++;
    if (q1 !== 1'b1) $display("FAIL clr_match_q: got %b want 1", q1);
    else n_pass++;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (cnt1 !== 4'd0) $display("FAIL clr_wins: got %0d want 0", cnt1);
    else n_pass++;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (cnt1 !== 4'd1) $display("FAIL clr_next: got %0d want 1", cnt1);
    else n_pass++;
  endtask

  task automatic test_pat4_load();
    logic [3:0] dbits = 4'b0110;
    logic [3:0] dexp  = 4'b0001;
    logic [2:0] ibits = 3'b101;
    logic [6:0] bits  = 7'b1101101;
    logic [6:0] expq  = 7'b0001001;
    // Default pattern is live straight out of reset.
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b1, dbits[i], 1'b0, 1'b0);
      n_total++;
      if (q2 !== dexp[i]) $display("FAIL p4_default_q bit%0d: got %b want %b", 4 - i, q2, dexp[i]);
      else n_pass++;
    end
    // A consumed load-cycle bit would make 1,0,1 complete 1101.
    do_reset();
    cfg_pat4 = 4'b1101;
    cfg_overlap = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (q2 !== 1'b0) $display("FAIL p4_load_q: got %b want 0", q2);
    else n_pass++;
    for (int i = 2; i >= 0; i--) begin
      cyc(1'b1, ibits[i], 1'b0, 1'b0);
      n_total++;
      if (q2 !== 1'b0) $display("FAIL p4_ignore_q bit%0d: got %b want 0", 3 - i, q2);
      else n_pass++;
    end
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, bits[i], 1'b0, 1'b0);
      n_total++;
      if (q2 !== expq[i]) $display("FAIL p4_ovl_q bit%0d: got %b want %b", 7 - i, q2, expq[i]);
      else n_pass++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (cnt2 !== 8'd2) $display("FAIL p4_cnt: got %0d want 2", cnt2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_en_gating();
    test_reset_midstream();
    test_saturation();
    test_pat4_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Mealy serial-pattern detector that succeeds the fixed 3-bit "101" detector. It generalises to a runtime-loadable pattern of PAT_W bits, selects overlapping or non-overlapping detection, adds a sample-enable qualifier, and keeps a saturating match counter. It sits on a single-bit serial data path and provides a same-cycle match flag (q_out) and a match count (match_cnt) for status readback.

Parameters:
PAT_W, 3, pattern length in bits; legal range 2..16.
CNT_W, 8, width of match_cnt.
DEFAULT_PATTERN, 3'b101 (PAT_W bits), pattern value after reset.
DEFAULT_OVERLAP, 1, detection mode after reset; 1 = overlapping, 0 = non-overlapping.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
en  input  1  sample qualifier; d_in is consumed only on cycles where en=1.
d_in  input  1  serial data bit.
cfg_load  input  1  one-cycle pulse that loads cfg_pattern and cfg_overlap.
cfg_pattern  input  PAT_W  new pattern; the MSB is the first bit received.
cfg_overlap  input  1  new mode (1 = overlapping).
cnt_clr  input  1  synchronous clear of match_cnt.
q_out  output  1  Mealy match flag; combinational and valid in the same cycle as the completing d_in.
match_cnt  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset is asynchronous and active-low (reset_n=0). Internal state after reset:
  - pat_r = DEFAULT_PATTERN
  - mode_r = DEFAULT_OVERLAP
  - hist = 0 (PAT_W-1 bits)
  - fill = 0 (range 0..PAT_W-1)
  - match_cnt = 0
  - q_out = 0 while reset_n=0
- Reset asserted mid-stream discards all history. The first possible match after release is on the PAT_W-th enabled bit.
- Match condition: q_out = en & ~cfg_load & (fill == PAT_W-1) & ({hist, d_in} == pat_r).
  - hist[PAT_W-2] is the oldest stored bit.
  - q_out is a Mealy output and may glitch. Consumers sample it only on the clk edge.
- Priority order at a clock edge: cfg_load, then en.
- cfg_load=1:
  - pat_r <= cfg_pattern, mode_r <= cfg_overlap.
  - hist <= 0, fill <= 0.
  - The d_in on that cycle is ignored, even if en=1.
  - match_cnt is unaffected.
- en=1 and cfg_load=0:
  - If q_out=1 and mode_r=0 (non-overlapping): fill <= 0, hist <= 0. The matched bits are consumed and cannot start the next match.
  - Otherwise: hist <= {hist[PAT_W-3:0], d_in} (for PAT_W=2, hist <= d_in), and fill <= min(fill+1, PAT_W-1).
- en=0: hist and fill hold, and q_out=0.
- Warm-up: no match is possible until PAT_W enabled bits have been received since the last reset, cfg_load, or non-overlap match.
- Counter:
  - match_cnt <= match_cnt+1 at each edge where q_out=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 forces match_cnt <= 0. cnt_clr wins over a simultaneous match, so the result is 0 and the match is lost.
- Latency: q_out has 0 cycles of latency from the completing d_in. match_cnt reflects the match 1 cycle later.
- No internal state depends on d_in when en=0 or cfg_load=1.
- Synthesisable with the default parameters and with PAT_W=2 and PAT_W=16.

Test Plan:
1. Defaults (PAT_W=3, pattern 101, overlap). Reset, then enabled stream 1,0,1,0,1. Required: q_out=1 on bits 3 and 5 only, and match_cnt=2 one cycle after bit 5.
2. cfg_load cfg_pattern=101, cfg_overlap=0, then stream 1,0,1,0,1,0,1. Required: q_out=1 on bits 3 and 7 only, and match_cnt=2.
3. en gating. Stream 1,0 with en=1, then two cycles of en=0 with d_in=0, then 1 with en=1. Required: q_out=0 during the en=0 cycles and q_out=1 on the final bit.
4. Reset mid-stream. After 1,0, pulse reset_n=0 for 3 ns, then send 1,0,1. Required: q_out=0 on the first 1 after release, q_out=1 on the third bit, and match_cnt=1.
5. CNT_W=4, continuous overlapping 101 match train of 20 matches. Required: match_cnt saturates at 15. cnt_clr together with a match yields 0, and the next match yields 1.
6. PAT_W=4, cfg_load 1101 mid-stream with en=1. Required: the d_in on the load cycle is ignored, stream 1,1,0,1 gives q_out=1 on the 4th bit, and 1,1,0,1,1,0,1 in overlap mode gives matches on bits 4 and 7.
